imem_sync_loadable: RTL and testbench

- Parametrised, synchronous, loadable instruction memory for the single-cycle/multicycle MIPS datapath.
- Generalised successor to the fixed combinational program ROM: it adds configurable width and depth, a registered fetch port with a valid flag, and a run-time program load port.
- A post-reset clear sequencer initialises the array before `ready` asserts.
- Sits between the PC/fetch stage and an external program loader (UART/JTAG bridge).

---
 rtl/imem_pkg.sv | 70 +++++++
 rtl/imem_ram_1r1w.sv | 36 +++
 rtl/imem_sync_loadable.sv | 182 ++++++++++++++++++
 tb/tb_imem_sync_loadable.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM and fetch-source
// encodings, the default fill word, the optional boot program table and the
// MIPS opcode/funct field constants used by the decoder.
package imem_pkg;

    // Memory controller states: initialise the array, then serve fetch/load.
    typedef enum logic {
        CLEAR,
        READY
    } imem_state_t;

    // Where the fetch output word comes from after the last accepted fetch.
    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_NOP,
        SRC_RAM
    } fetch_src_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // MIPS primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // MIPS R-type funct codes.
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Boot program written by the clear sequence when the boot option is built in.
    localparam int BOOT_LEN   = 8;
    localparam int BOOT_IDX_W = 3;

    localparam logic [0:BOOT_LEN-1][31:0] BOOT_PROG = '{
        32'h2001_0003,   // addi $1,$0,3
        32'h2002_0005,   // addi $2,$0,5
        32'h0022_1820,   // add  $3,$1,$2
        32'h0041_2022,   // sub  $4,$2,$1
        32'h0022_2824,   // and  $5,$1,$2
        32'h0022_3025,   // or   $6,$1,$2
        32'h0022_382A,   // slt  $7,$1,$2
        32'h1000_FFFF    // beq  $0,$0,-1
    };

    // Boot table lookup; indices past the table return the default fill word.
    function automatic logic [31:0] boot_word(input logic [31:0] idx);
        logic [31:0] word;
        word = NOP_WORD_DEFAULT;
        if (idx < 32'(BOOT_LEN)) begin
            word = BOOT_PROG[idx[BOOT_IDX_W-1:0]];
        end
        return word;
    endfunction

    // Instruction field extraction helpers for the decoder.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Plain DEPTH x DATA_W storage array with one synchronous write port and one
// registered read port. A read and a write to the same word on the same edge
// return the old contents (read-before-write). No control logic lives here.
module imem_ram_1r1w
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its word when no read is requested.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync_loadable.sv
// Synchronous loadable instruction memory for the MIPS datapath.
// After reset a clear sequencer fills every word (NOP_WORD, or the boot program
// followed by NOP_WORD when IMEM_BOOT_PROG_EN is defined), then raises ready.
// While ready, a registered fetch port (1-cycle latency, fetch_valid flag) and a
// program load port (with a saturating accepted-write counter) are served.
// Optional build macro: IMEM_BOOT_PROG_EN.
module imem_sync_loadable
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W:0]   ld_count
);

    // One extra bit so a full 2**ADDR_W clear ends without wrapping.
    localparam int              PTR_W    = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);

    imem_state_t       state;
    imem_state_t       state_next;
    logic [PTR_W-1:0]  clr_ptr;
    logic              clr_we;

    logic              fetch_in_range;
    logic              ld_in_range;
    logic              fetch_accept;
    logic              ld_accept;
    fetch_src_t        src_q;

    logic [DATA_W-1:0] fill_word;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR after the last word has been written.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR: begin
                if (clr_ptr == LAST_PTR) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // State outputs: clear writes while initialising, ready afterwards.
    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        case (state)
            CLEAR:   clr_we = 1'b1;
            READY:   ready  = 1'b1;
            default: begin
                ready  = 1'b0;
                clr_we = 1'b0;
            end
        endcase
    end

    // Clear pointer walks the array once per reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_ptr <= '0;
        end else if (clr_we) begin
            clr_ptr <= clr_ptr + PTR_W'(1);
        end
    end

    // Address range checks and request qualification.
    always_comb begin
        fetch_in_range = ({1'b0, fetch_addr} < DEPTH_P);
        ld_in_range    = ({1'b0, ld_addr} < DEPTH_P);
        fetch_accept   = ready && fetch_en;
        ld_accept      = ready && ld_en && ld_in_range;
    end

`ifdef IMEM_BOOT_PROG_EN
    localparam int BOOT_EFF = (BOOT_LEN < DEPTH) ? BOOT_LEN : DEPTH;

    // Clear fill word: boot program first, NOP_WORD for the rest.
    always_comb begin
        fill_word = NOP_WORD;
        if (clr_ptr < PTR_W'(BOOT_EFF)) begin
            fill_word = DATA_W'(boot_word(32'(clr_ptr)));
        end
    end
`else
    // Clear fill word: the whole array becomes NOP_WORD.
    always_comb begin
        fill_word = NOP_WORD;
    end
`endif

    // Write port mux: the clear sequence owns the port until ready.
    always_comb begin
        ram_we    = ld_accept;
        ram_waddr = ld_addr;
        ram_wdata = ld_data;
        if (clr_we) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr[ADDR_W-1:0];
            ram_wdata = fill_word;
        end
    end

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (fetch_accept && fetch_in_range),
        .raddr (fetch_addr),
        .rdata (ram_rdata)
    );

    // Fetch response tracking: valid flag and which source feeds fetch_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            src_q       <= SRC_ZERO;
        end else begin
            fetch_valid <= fetch_accept;
            if (fetch_accept) begin
                src_q <= fetch_in_range ? SRC_RAM : SRC_NOP;
            end
        end
    end

    // Fetch data select: zero after reset, NOP for out-of-range, else RAM word.
    always_comb begin
        case (src_q)
            SRC_RAM: fetch_data = ram_rdata;
            SRC_NOP: fetch_data = NOP_WORD;
            default: fetch_data = '0;
        endcase
    end

    // Saturating count of accepted load writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_count <= '0;
        end else if (ld_accept && (ld_count != '1)) begin
            ld_count <= ld_count + PTR_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Scoreboard testbench for imem_sync_loadable (DEPTH=200 so out-of-range
// addresses exist). The driver keeps a word-array reference model, pushes the
// expected fetch word for each accepted fetch, and a monitor pops and compares
// whenever fetch_valid is seen, alongside ready, ld_count and the hold value.
module tb_imem_sync_loadable;
    import imem_pkg::*;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 200;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ready;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [ADDR_W:0]   ld_count;

    imem_sync_loadable #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_count    (ld_count)
    );

    always #5 clk = ~clk;

    // Reference model state (values expected after the next clock edge).
    logic [31:0] model_mem [256];
    int          clr_edges;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_hold;
    logic [8:0]  exp_count;
    logic [31:0] sb_q [$];
    logic        mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Contents every word holds once a clear sequence has finished.
    task automatic modelClear();
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = NOP;
`ifdef IMEM_BOOT_PROG_EN
            if (i < BOOT_LEN && i < DEPTH) model_mem[i] = boot_word(32'(i));
`endif
        end
    endtask

    // Drive one cycle of requests (called at a falling edge) and advance the model.
    task automatic applyStimulus(input logic fe, input logic [7:0] fa, input logic le,
                                 input logic [7:0] la, input logic [31:0] ld);
        logic        honoured;
        logic [31:0] word;
        honoured = (clr_edges >= DEPTH);
        exp_valid = 1'b0;
        if (honoured && fe) begin
            word = (int'(fa) < DEPTH) ? model_mem[fa] : NOP;
            sb_q.push_back(word);
            exp_hold  = word;
            exp_valid = 1'b1;
        end
        if (honoured && le && int'(la) < DEPTH) begin
            model_mem[la] = ld;
            if (exp_count != 9'h1FF) exp_count = exp_count + 9'd1;
        end
        clr_edges++;
        exp_ready  = (clr_edges >= DEPTH);
        fetch_en   = fe;
        fetch_addr = fa;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyRandom(input int n);
        logic        fe, le;
        logic [7:0]  fa, la;
        logic [31:0] ld;
        for (int k = 0; k < n; k++) begin
            fe = 1'($urandom_range(0, 1));
            le = 1'($urandom_range(0, 1));
            fa = 8'($urandom_range(0, 255));
            la = 8'($urandom_range(0, 255));
            ld = $urandom;
            applyStimulus(fe, fa, le, la, ld);
        end
    endtask

    // Assert reset between edges, hold two edges, release at a falling edge.
    task automatic doReset();
        fetch_en  = 1'b0;
        ld_en     = 1'b0;
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        exp_hold  = '0;
        exp_count = '0;
        clr_edges = 0;
        modelClear();
        mon_en    = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver.
    initial begin
        @(negedge clk);
        doReset();
        applyRandom(DEPTH);
        applyStimulus(1'b1, 8'h80, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h05, 32'h0022_1020);
        applyStimulus(1'b1, 8'h05, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b1, 8'h05, 1'b1, 8'h05, 32'h0022_1824);
        applyStimulus(1'b1, 8'h05, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b1, 8'hC8, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hC8, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 8'hC8, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b1, 8'(BOOT_LEN), 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        applyRandom(1500);
        doReset();
        applyRandom(100);
        doReset();
        applyRandom(DEPTH + 300);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: reset values while rst is high, scoreboard and model otherwise.
    initial begin
        wait (mon_en);
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (rst) begin
                checkOutput("rst_ready", 32'(ready), 32'h0);
                checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'h0);
                checkOutput("rst_fetch_data", fetch_data, 32'h0);
                checkOutput("rst_ld_count", 32'(ld_count), 32'h0);
            end else begin
                checkOutput("ready", 32'(ready), 32'(exp_ready));
                checkOutput("ld_count", 32'(ld_count), 32'(exp_count));
                checkOutput("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
                if (fetch_valid === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL fetch_unexpected: got 0x%0h, expected no response at %0t", fetch_data, $time);
                    end else begin
                        checkOutput("fetch_data", fetch_data, sb_q.pop_front());
                    end
                end else begin
                    checkOutput("fetch_hold", fetch_data, exp_hold);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
